// File: rtl/dm_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dm_arb_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 4;
    // Wide enough for a beat index up to 15 (MAX_BURST of 16).
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not own last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    assign winner = req1 & (~req0 | ~last);

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the processor (0) and network interface (1) onto one data-memory port,
// with round-robin selection and bounded locked bursts.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

    arb_state_e       state, state_nxt;
    logic             last_owner, last_owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             winner;
    logic             beat0, beat1;

    logic [DATA_W-1:0] rd0_p1, rd1_p1;
    logic              rvld0_p1, rvld1_p1;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_owner),
        .winner (winner)
    );

    assign gnt0  = (state == OWN0);
    assign gnt1  = (state == OWN1);
    assign beat0 = gnt0 & req0;
    assign beat1 = gnt1 & req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // An owner keeps the port while locked and under the limit; otherwise the other side
    // takes over directly, or an unlocked owner is re-granted if nobody else wants it.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = winner ? OWN1 : OWN0;
                    cnt_nxt   = '0;
                end
            end
            OWN0: begin
                if (req0 && lock0 && (cnt < CNT_LIM)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                    if (req1) begin
                        state_nxt      = OWN1;
                        last_owner_nxt = 1'b0;
                    end else if (!(req0 && !lock0)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = 1'b0;
                    end
                end
            end
            OWN1: begin
                if (req1 && lock1 && (cnt < CNT_LIM)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                    if (req0) begin
                        state_nxt      = OWN0;
                        last_owner_nxt = 1'b1;
                    end else if (!(req1 && !lock1)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (beat0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (beat1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // ---- stage p1: read data captured at the end of a read beat ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvld0_p1 <= 1'b0;
            rvld1_p1 <= 1'b0;
            rd0_p1   <= '0;
            rd1_p1   <= '0;
        end else begin
            rvld0_p1 <= beat0 & ~we0;
            rvld1_p1 <= beat1 & ~we1;
            if (beat0 && !we0) rd0_p1 <= mem_rdata;
            if (beat1 && !we1) rd1_p1 <= mem_rdata;
        end
    end

    assign rvalid0 = rvld0_p1;
    assign rvalid1 = rvld1_p1;
    assign rdata0  = rd0_p1;
    assign rdata1  = rd1_p1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and randomised checks of dm_arbiter against a behavioural memory and arbiter model.
module tb_dm_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [15:0] ref_mem [16];
    logic        rq [2];
    logic        lk [2];
    logic        wv [2];
    logic [15:0] av [2];
    logic [15:0] dv [2];
    int          m_own, m_cnt, b;
    logic        m_last;
    logic        exp_rv0, exp_rv1, exp_we;
    logic [15:0] exp_rd0, exp_rd1, exp_addr;

    dm_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pre_we = 0; pre_addr = 0; pre_data = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Preload the backing memory while the arbiter is held in reset.
        pre_we = 1;
        pre_addr = 16'h0010; pre_data = 16'hBEEF; tick();
        pre_addr = 16'h0003; pre_data = 16'h0000; tick();
        for (int i = 0; i < 16; i++) begin
            pre_addr = 16'h0020 + 16'(i); pre_data = 16'h0000; ref_mem[i] = 16'h0000;
            tick();
        end
        pre_we = 0;
        rst = 1'b1;

        // Single read by requester 0.
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        #1;
        chk("rd_idle_gnt0", gnt0, 0);
        tick();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_mem_addr", mem_addr, 16'h0010);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_rvalid0_early", rvalid0, 0);
        tick();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 16'hBEEF);
        req0 = 0;
        #1;
        chk("rd_nobeat_addr", mem_addr, 0);
        tick();
        chk("rd_rvalid0_pulse", rvalid0, 0);
        chk("rd_gnt0_off", gnt0, 0);
        chk("rd_rdata0_hold", rdata0, 16'hBEEF);

        // Write by requester 1, then read it back via requester 0.
        req1 = 1; we1 = 1; addr1 = 16'h0003; wdata1 = 16'h1234;
        #1;
        chk("wr_idle_we", mem_we, 0);
        tick();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 16'h0003);
        chk("wr_mem_wdata", mem_wdata, 16'h1234);
        tick();
        req1 = 0; we1 = 0;
        #1;
        chk("wr_single_pulse", mem_we, 0);
        tick();
        chk("wr_gnt1_off", gnt1, 0);
        chk("wr_no_rvalid1", rvalid1, 0);
        req0 = 1; we0 = 0; addr0 = 16'h0003;
        tick();
        chk("wrrd_gnt0", gnt0, 1);
        chk("wrrd_addr", mem_addr, 16'h0003);
        tick();
        chk("wrrd_rvalid0", rvalid0, 1);
        chk("wrrd_rdata0", rdata0, 16'h1234);
        req0 = 0;
        tick();

        // Tie straight after reset: requester 0 first, then 1 with no idle gap.
        rst = 1'b0;
        #1;
        chk("rst2_rdata0", rdata0, 0);
        tick();
        rst = 1'b1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0010; addr1 = 16'h0003;
        tick();
        chk("tie_gnt0_first", gnt0, 1);
        chk("tie_gnt1_wait", gnt1, 0);
        tick();
        chk("tie_gnt0_release", gnt0, 0);
        chk("tie_gnt1_next", gnt1, 1);
        chk("tie_rvalid0", rvalid0, 1);
        chk("tie_rdata0", rdata0, 16'hBEEF);
        tick();
        chk("tie_gnt0_again", gnt0, 1);
        chk("tie_rvalid1", rvalid1, 1);
        chk("tie_rdata1", rdata1, 16'h1234);
        req0 = 0; req1 = 0;
        tick();
        chk("tie_idle_gnt0", gnt0, 0);
        chk("tie_idle_gnt1", gnt1, 0);

        // Locked burst from requester 0 is cut after MB beats when 1 is waiting.
        req0 = 1; lock0 = 1; we0 = 0; addr0 = 16'h0010;
        tick();
        chk("burst_beat1", gnt0, 1);
        req1 = 1; we1 = 0; addr1 = 16'h0003;
        for (int i = 2; i <= MB; i++) begin
            tick();
            chk($sformatf("burst_beat%0d", i), gnt0, 1);
        end
        tick();
        chk("burst_end_gnt0", gnt0, 0);
        chk("burst_end_gnt1", gnt1, 1);
        req0 = 0; lock0 = 0; req1 = 0;
        tick();
        chk("burst_idle_gnt1", gnt1, 0);

        // Asynchronous reset in the second beat of a locked burst.
        req0 = 1; lock0 = 1; we0 = 0; addr0 = 16'h0010;
        tick();
        chk("mid_gnt0", gnt0, 1);
        tick();
        chk("mid_rvalid0", rvalid0, 1);
        we0 = 1; addr0 = 16'h0030; wdata0 = 16'h5555;
        #1;
        chk("mid_mem_we", mem_we, 1);
        chk("mid_gnt0_beat2", gnt0, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_gnt0", gnt0, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_rvalid0", rvalid0, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        tick();
        rst = 1'b1;

        // Random traffic against a behavioural arbiter and memory model.
        m_own = -1; m_cnt = 0; m_last = 1'b1;
        exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int r = 0; r < 2; r++) begin
                rq[r] = ($urandom_range(0, 3) != 0);
                lk[r] = 1'($urandom_range(0, 1));
                wv[r] = 1'($urandom_range(0, 1));
                av[r] = 16'h0020 + 16'($urandom_range(0, 15));
                dv[r] = 16'($urandom);
            end
            req0 = rq[0]; lock0 = lk[0]; we0 = wv[0]; addr0 = av[0]; wdata0 = dv[0];
            req1 = rq[1]; lock1 = lk[1]; we1 = wv[1]; addr1 = av[1]; wdata1 = dv[1];
            #1;
            b = (m_own >= 0 && rq[m_own]) ? m_own : -1;
            exp_we   = (b >= 0) ? wv[b] : 1'b0;
            exp_addr = (b >= 0) ? av[b] : 16'h0000;
            chk("rnd_excl", gnt0 & gnt1, 0);
            chk("rnd_gnt0", gnt0, (m_own == 0));
            chk("rnd_gnt1", gnt1, (m_own == 1));
            chk("rnd_mem_we", mem_we, exp_we);
            chk("rnd_mem_addr", mem_addr, exp_addr);
            chk("rnd_rvalid0", rvalid0, exp_rv0);
            chk("rnd_rvalid1", rvalid1, exp_rv1);
            chk("rnd_rdata0", rdata0, exp_rd0);
            chk("rnd_rdata1", rdata1, exp_rd1);

            exp_rv0 = (b == 0) && !wv[0];
            exp_rv1 = (b == 1) && !wv[1];
            if (exp_rv0) exp_rd0 = ref_mem[av[0][3:0]];
            if (exp_rv1) exp_rd1 = ref_mem[av[1][3:0]];
            if (b >= 0 && wv[b]) ref_mem[av[b][3:0]] = dv[b];

            if (m_own < 0) begin
                if (rq[0] && rq[1]) m_own = m_last ? 0 : 1;
                else if (rq[0])     m_own = 0;
                else if (rq[1])     m_own = 1;
                m_cnt = 0;
            end else if (rq[m_own] && lk[m_own] && m_cnt < MB - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                if (rq[1 - m_own]) begin
                    m_last = 1'(m_own);
                    m_own  = 1 - m_own;
                end else if (!(rq[m_own] && !lk[m_own])) begin
                    m_last = 1'(m_own);
                    m_own  = -1;
                end
            end
            tick();
        end
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rnd_mem_%0h", 16'h0020 + 16'(i)), mem[16'h0020 + 16'(i)], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the data-memory word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive beats per locked ownership (range 1..16).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0/req1  input  1  each  access request from requester 0 (processor) / requester 1 (network interface).
REQ-007 SHALL have ports lock0/lock1  input  1  each  request to keep ownership for a burst.
REQ-008 SHALL have ports we0/we1  input  1  each  write (1) or read (0) for the current beat.
REQ-009 SHALL have ports addr0/addr1  input  ADDR_W  each  beat address.
REQ-010 SHALL have ports wdata0/wdata1  input  DATA_W  each  beat write data.
REQ-011 SHALL have ports gnt0/gnt1  output  1  each  requester owns the memory port this cycle.
REQ-012 SHALL have ports rdata0/rdata1  output  DATA_W  each  registered read data.
REQ-013 SHALL have ports rvalid0/rvalid1  output  1  each  rdataN valid, one cycle pulse.
REQ-014 SHALL have port mem_we  output  1  data-memory write enable.
REQ-015 SHALL have ports mem_addr  output  ADDR_W  and  mem_wdata  output  DATA_W  data-memory address and write data.
REQ-016 SHALL have port mem_rdata  input  DATA_W  combinational data-memory read data.

Function
REQ-017 SHALL implement a state machine with states IDLE, OWN0, OWN1; gntN = 1 exactly when the state is OWNN (Moore output).
REQ-018 SHALL define a beat as a cycle with gntN=1 and reqN=1; in a beat, mem_addr=addrN, mem_wdata=wdataN, mem_we=weN.
REQ-019 SHALL drive mem_we=0, mem_addr=0, mem_wdata=0 in every cycle that is not a beat.
REQ-020 SHALL, on a read beat of requester N, register mem_rdata into rdataN and assert rvalidN for the following cycle only; rdataN holds its value otherwise.
REQ-021 SHALL arbitrate round-robin using a last-owner register: when both requesters compete, the requester that is not the last owner wins.
REQ-022 SHALL, from IDLE, go to OWNN on the next edge if reqN is the arbitration winner; stay in IDLE if no request.
REQ-023 SHALL count beats in OWNN with a counter cleared on entry; ownership continues while reqN=1, lockN=1 and the count < MAX_BURST-1.
REQ-024 SHALL, when ownership of N ends (reqN=0, lockN=0, or the burst limit is reached), go directly to OWN(other) if the other requester is requesting, else to IDLE; no bubble cycle.
REQ-025 SHALL, when a non-locked beat ends and the other requester is idle, re-grant N directly if reqN remains 1 (stay in OWNN, counter reset).
REQ-026 SHALL update last-owner to N on every transition out of OWNN.
REQ-027 SHALL ensure gnt0 and gnt1 are never simultaneously 1 and memory writes occur only on beats.
REQ-028 SHALL give fixed 1-cycle grant latency from IDLE (reqN rises at edge k -> gntN=1 in the cycle after edge k+1).

Reset
REQ-029 SHALL, on rst=0 at any time including mid-burst, asynchronously force IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, beat counter=0, last-owner=1 (requester 0 wins the first tie), memory outputs=0.
REQ-030 SHALL resume arbitration on the first rising clk after rst returns to 1; beats in progress at reset are lost.

Structure
REQ-031 SHALL take the state enumeration (IDLE/OWN0/OWN1) and the default widths from a shared package dm_arb_pkg.
REQ-032 SHALL be a single module; the round-robin pick is a natural sub-module rr_pick2 (inputs req0, req1, last; output winner).

Verification
REQ-033 SHALL cover single read: req0=1, we0=0, addr0=0x0010, memory[0x0010]=0xBEEF -> gnt0 two edges after req, rvalid0 pulse next cycle with rdata0=0xBEEF.
REQ-034 SHALL cover write: req1=1, we1=1, addr1=0x0003, wdata1=0x1234 -> exactly one mem_we pulse; a later read of 0x0003 returns 0x1234.
REQ-035 SHALL cover tie after reset: req0=req1=1 simultaneously -> gnt0 first, then gnt1 with no IDLE cycle between.
REQ-036 SHALL cover burst limit: lock0=1, req0 held, req1 held, MAX_BURST=4 -> exactly 4 beats for requester 0, then gnt1.
REQ-037 SHALL cover reset mid-burst: assert rst=0 during the 2nd beat of a locked burst -> gnt0, mem_we and rvalid0 drop immediately, with no clock edge required.
REQ-038 SHALL cover mutual exclusion: random req/lock/we for 10,000 cycles -> gnt0&gnt1 never 1, and data memory contents match a reference model.
